data_bus_access_unit: RTL and testbench
=======================================

// Module: data_bus_access_unit
// PURPOSE
//  Registered successor to the combinational data bus control unit.
//  Sits between the core's load/store stage and the data bus.
//  Supports byte, halfword and word accesses with byte enables and load sign/zero extension.
//  Adds a ready/wait-state handshake, misalignment detection and a one-cycle done pulse.
// PARAMETERS
//  ADDR_WIDTH      32  width of addr_in / data_bus_addr
//  TIMEOUT_CYCLES  16  max wait cycles for data_bus_ready (used only with DBUS_TIMEOUT_EN); >=1
// PORTS
//  clk             in   1           clock, all state on rising edge
//  reset           in   1           synchronous, active-high reset
//  cs_bus_read     in   1           load request (sampled in IDLE only)
//  cs_bus_write    in   1           store request (sampled in IDLE only; wins over read)
//  funct3          in   3           RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr_in         in   ADDR_WIDTH  byte address
//  data_in         in   32          store data, right-aligned
//  data_out        out  32          extended load result, held until next load completes
//  busy            out  1           high while not IDLE
//  done            out  1           one-cycle pulse at access completion
//  error           out  1           valid with done: 1 = misaligned, illegal funct3 or timeout
//  data_bus_addr   out  ADDR_WIDTH  latched address, low 2 bits forced to 0
//  data_bus_wdata  out  32          lane-positioned store data
//  data_bus_rdata  in   32          read data from bus
//  data_bus_mode   out  2           00 idle, 01 read, 10 write
//  data_bus_be     out  4           byte enables, 0 when mode == 00
//  data_bus_ready  in   1           slave completes the access this cycle
// BEHAVIOUR
//  Reset: state=IDLE; data_out=0, busy=0, done=0, error=0, data_bus_mode=00, data_bus_be=0,
//   data_bus_addr=0, data_bus_wdata=0. Reset mid-access aborts it; no done pulse is issued.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. Also IDLE -> DONE on a rejected request.
//  IDLE: cs_bus_write|cs_bus_read latches addr_in, data_in, funct3 and direction.
//   Write wins if both are high.
//   Misaligned requests go to DONE with error=1 and never drive the bus:
//    H/HU with addr[0]!=0; W with addr[1:0]!=0.
//   Illegal funct3 (011, 110, 111; 100/101 on a store) is handled the same way.
//   Otherwise the request goes to ACCESS.
//  ACCESS: drive mode, address, byte enables and wdata from registers; hold them stable until ready.
//   B lane=addr[1:0] (be=0001<<lane); H lane=addr[1] (be=0011<<2*addr[1]); W be=1111.
//   wdata = data_in shifted into the selected lane(s); unused lanes 0.
//   data_bus_ready=1: for a load, extract lane from rdata and sign-extend (B/H) or zero-extend (BU/HU).
//    Register the result into data_out; go to DONE.
//  DONE: done=1 for exactly one cycle, mode=00, be=0; go to IDLE.
//   Requests present during DONE are ignored. A new request may be accepted in the following IDLE cycle.
//  Latency: ready already high in the first ACCESS cycle -> done in cycle 2 after the request cycle.
//   Each wait cycle adds 1. Rejected request -> done in cycle 1.
//  data_out changes only on successful load completion; stores and errors leave it unchanged.
//  data_bus_ready outside ACCESS is ignored.
// CONFIGURATION
//  DBUS_TIMEOUT_EN defined: wait counter cleared on ACCESS entry and incremented per cycle without ready.
//   If the counter reaches TIMEOUT_CYCLES, the access is dropped -> DONE with error=1.
//   Ready in the same cycle as expiry counts as success.
//  DBUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for data_bus_ready.
// TESTING
//  LB at 0x103, ready immediate, rdata=0x80123456 -> be=1000, done at +2, data_out=0xFFFFFF80, error=0.
//  LHU at 0x102, rdata=0xBEEF0000 -> be=1100, data_out=0x0000BEEF.
//  SB at 0x201, data_in=0x000000AB -> mode=10, be=0010, wdata=0x0000AB00, addr=0x200.
//  SW at 0x301 -> done+error at +1, mode stays 00 throughout; data_out unchanged.
//  LW at 0x400, ready after 3 wait cycles -> outputs stable during the wait, done at +5.
//   Repeat with reset asserted in a wait cycle -> next cycle IDLE, mode=00, no done.
//  With DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready held low -> done+error after 4 ACCESS cycles.
//   Read+write asserted together -> store performed.

Source files
------------

// File: rtl/data_bus_access_unit.sv
// data_bus_access_unit
// Registered load/store interface between the core's load/store stage and
// the data bus. Handles byte/halfword/word accesses with byte enables,
// load sign/zero extension, a ready/wait-state handshake, misalignment and
// illegal-size rejection, and a one-cycle done pulse.
//
// Optional feature: define DBUS_TIMEOUT_EN to bound the number of wait
// cycles spent in ACCESS to TIMEOUT_CYCLES; the access is then dropped and
// completes with error=1. Without it, ACCESS waits indefinitely for ready.
module data_bus_access_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_bus_read,
   input  logic                  cs_bus_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] data_bus_addr,
   output logic [31:0]           data_bus_wdata,
   input  logic [31:0]           data_bus_rdata,
   output logic [1:0]            data_bus_mode,
   output logic [3:0]            data_bus_be,
   input  logic                  data_bus_ready
);

   // ------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;

`ifdef DBUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                state_q,    state_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [1:0]            lane_q,     lane_d;
   logic [31:0]           wdata_q,    wdata_d;
   logic [3:0]            be_q,       be_d;
   logic [2:0]            funct3_q,   funct3_d;
   logic                  write_q,    write_d;
   logic [31:0]           data_out_q, data_out_d;
   logic                  error_q,    error_d;
`ifdef DBUS_TIMEOUT_EN
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
`endif

   // ------------------------------------------------------------------
   // Request decode: legality, alignment, byte enables and lane-shifted
   // store data, all from the live request inputs (used in IDLE only).
   // ------------------------------------------------------------------
   logic        req_valid;
   logic        req_ok;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   assign req_valid = cs_bus_write | cs_bus_read;

   // Classify the incoming request and pre-compute its bus lanes.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      req_ok    = 1'b0;
      req_be    = 4'b0000;
      req_wdata = 32'h0;

      case (funct3)
         F3_B:    req_ok = 1'b1;
         F3_H:    req_ok = ~addr_in[0];
         F3_W:    req_ok = (addr_in[1:0] == 2'b00);
         F3_BU:   req_ok = ~cs_bus_write;
         F3_HU:   req_ok = ~cs_bus_write & ~addr_in[0];
         default: req_ok = 1'b0;
      endcase

      case (funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << addr_in[1:0];
            req_wdata = {24'h0, data_in[7:0]} << {addr_in[1:0], 3'b000};
         end
         2'b01: begin
            req_be    = addr_in[1] ? 4'b1100 : 4'b0011;
            req_wdata = addr_in[1] ? {data_in[15:0], 16'h0}
                                   : {16'h0, data_in[15:0]};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = data_in;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Load extraction: shift the addressed lane down to bit 0, then extend.
   // Halfwords are always 2-byte aligned here, so the byte shift by the
   // full lane index also selects the correct half.
   // ------------------------------------------------------------------
   logic [31:0] rdata_shifted;
   logic [31:0] load_data;

   assign rdata_shifted = data_bus_rdata >> {lane_q, 3'b000};

   // Sign- or zero-extend the selected lane according to the latched size.
   always_comb begin
      load_data = rdata_shifted;
      case (funct3_q)
         F3_B:    load_data = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
         F3_H:    load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         F3_BU:   load_data = {24'h0, rdata_shifted[7:0]};
         F3_HU:   load_data = {16'h0, rdata_shifted[15:0]};
         default: load_data = rdata_shifted;
      endcase
   end

   // ------------------------------------------------------------------
   // Next-state logic for the access FSM and its datapath registers.
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      bus_addr_d = bus_addr_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      funct3_d   = funct3_q;
      write_d    = write_q;
      data_out_d = data_out_q;
      error_d    = error_q;
`ifdef DBUS_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               funct3_d = funct3;
               write_d  = cs_bus_write;
               if (req_ok) begin
                  // Bus-facing registers only move on accepted requests so a
                  // rejected one never touches the bus.
                  bus_addr_d = {addr_in[ADDR_WIDTH-1:2], 2'b00};
                  lane_d     = addr_in[1:0];
                  be_d       = req_be;
                  wdata_d    = cs_bus_write ? req_wdata : 32'h0;
                  error_d    = 1'b0;
                  state_d    = ST_ACCESS;
`ifdef DBUS_TIMEOUT_EN
                  cnt_d      = '0;
`endif
               end else begin
                  error_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_ACCESS: begin
            if (data_bus_ready) begin
               if (!write_q) begin
                  data_out_d = load_data;
               end
               error_d = 1'b0;
               state_d = ST_DONE;
            end
`ifdef DBUS_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               // Last permitted wait cycle without ready: drop the access.
               error_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register with synchronous reset; reset aborts any access.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      if (reset) begin
         state_q    <= ST_IDLE;
         bus_addr_q <= '0;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0;
         be_q       <= 4'b0000;
         funct3_q   <= 3'b000;
         write_q    <= 1'b0;
         data_out_q <= 32'h0;
         error_q    <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bus_addr_q <= bus_addr_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         funct3_q   <= funct3_d;
         write_q    <= write_d;
         data_out_q <= data_out_d;
         error_q    <= error_d;
`ifdef DBUS_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from registers only, so they are stable for the
   // whole of each state.
   // ------------------------------------------------------------------
   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign error          = done & error_q;
   assign data_out       = data_out_q;
   assign data_bus_addr  = bus_addr_q;
   assign data_bus_wdata = wdata_q;
   assign data_bus_mode  = (state_q != ST_ACCESS) ? MODE_IDLE
                         : (write_q ? MODE_WRITE : MODE_READ);
   assign data_bus_be    = (state_q == ST_ACCESS) ? be_q : 4'b0000;

endmodule

// File: tb/tb_data_bus_access_unit.sv
// tb_data_bus_access_unit
// Directed self-checking bench for data_bus_access_unit. Expected values
// are hand-computed constants. Define DBUS_TIMEOUT_EN to also exercise the
// wait-cycle timeout with TIMEOUT_CYCLES=4.
module tb_data_bus_access_unit;

`ifdef DBUS_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 16;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_bus_read;
   logic        cs_bus_write;
   logic [2:0]  funct3;
   logic [31:0] addr_in;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] data_bus_addr;
   logic [31:0] data_bus_wdata;
   logic [31:0] data_bus_rdata;
   logic [1:0]  data_bus_mode;
   logic [3:0]  data_bus_be;
   logic        data_bus_ready;

   int n_checks = 0;
   int n_errors = 0;

   data_bus_access_unit #(
      .ADDR_WIDTH    (32),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cs_bus_read   (cs_bus_read),
      .cs_bus_write  (cs_bus_write),
      .funct3        (funct3),
      .addr_in       (addr_in),
      .data_in       (data_in),
      .data_out      (data_out),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .data_bus_addr (data_bus_addr),
      .data_bus_wdata(data_bus_wdata),
      .data_bus_rdata(data_bus_rdata),
      .data_bus_mode (data_bus_mode),
      .data_bus_be   (data_bus_be),
      .data_bus_ready(data_bus_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns in the first cycle after it.
   task automatic request(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
      cs_bus_read  = rd;
      cs_bus_write = wr;
      funct3       = f3;
      addr_in      = a;
      data_in      = d;
      step();
      cs_bus_read  = 1'b0;
      cs_bus_write = 1'b0;
   endtask

   // Check the bus-side view of an ACCESS cycle.
   task automatic check_access(input string tag, input logic [1:0] mode,
                               input logic [3:0] be, input logic [31:0] a);
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".mode"}, 32'(data_bus_mode), 32'(mode));
      check({tag, ".be"},   32'(data_bus_be), 32'(be));
      check({tag, ".addr"}, data_bus_addr, a);
   endtask

   // Check the DONE cycle, then the following return to IDLE.
   task automatic check_done(input string tag, input logic err, input logic [31:0] dout);
      check({tag, ".done"},  32'(done), 32'd1);
      check({tag, ".error"}, 32'(error), 32'(err));
      check({tag, ".mode0"}, 32'(data_bus_mode), 32'd0);
      check({tag, ".be0"},   32'(data_bus_be), 32'd0);
      check({tag, ".dout"},  data_out, dout);
      step();
      check({tag, ".idle_done"}, 32'(done), 32'd0);
      check({tag, ".idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      cs_bus_read    = 1'b0;
      cs_bus_write   = 1'b0;
      funct3         = 3'b000;
      addr_in        = 32'h0;
      data_in        = 32'h0;
      data_bus_rdata = 32'h0;
      data_bus_ready = 1'b0;
      step();
      step();

      // Reset state
      check("rst.busy",  32'(busy), 32'd0);
      check("rst.done",  32'(done), 32'd0);
      check("rst.error", 32'(error), 32'd0);
      check("rst.mode",  32'(data_bus_mode), 32'd0);
      check("rst.be",    32'(data_bus_be), 32'd0);
      check("rst.addr",  data_bus_addr, 32'h0);
      check("rst.wdata", data_bus_wdata, 32'h0);
      check("rst.dout",  data_out, 32'h0);
      reset = 1'b0;
      step();

      // LB 0x103, ready immediate: be=1000, done in cycle 2, sign-extended 0x80
      data_bus_ready = 1'b1;
      data_bus_rdata = 32'h8012_3456;
      request(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
      check_access("lb", 2'b01, 4'b1000, 32'h0000_0100);
      step();
      check_done("lb", 1'b0, 32'hFFFF_FF80);

      // LHU 0x102: upper half, zero-extended
      data_bus_rdata = 32'hBEEF_0000;
      request(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0);
      check_access("lhu", 2'b01, 4'b1100, 32'h0000_0100);
      step();
      check_done("lhu", 1'b0, 32'h0000_BEEF);

      // LH 0x000: lower half, sign-extended
      data_bus_rdata = 32'h1234_8001;
      request(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0);
      check_access("lh", 2'b01, 4'b0011, 32'h0000_0000);
      step();
      check_done("lh", 1'b0, 32'hFFFF_8001);

      // LBU 0x001: lane 1, zero-extended
      data_bus_rdata = 32'h0000_FF00;
      request(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0);
      check_access("lbu", 2'b01, 4'b0010, 32'h0000_0000);
      step();
      check_done("lbu", 1'b0, 32'h0000_00FF);

      // SB 0x201: lane 1 write; data_out untouched
      request(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB);
      check_access("sb", 2'b10, 4'b0010, 32'h0000_0200);
      check("sb.wdata", data_bus_wdata, 32'h0000_AB00);
      step();
      check_done("sb", 1'b0, 32'h0000_00FF);

      // SW 0x301 misaligned: done+error at +1, bus never driven.
      // A request presented during DONE must be ignored.
      request(1'b0, 1'b1, 3'b010, 32'h0000_0301, 32'h1111_2222);
      check("sw_mis.mode", 32'(data_bus_mode), 32'd0);
      check("sw_mis.addr_kept", data_bus_addr, 32'h0000_0200);
      cs_bus_read = 1'b1;
      funct3      = 3'b010;
      addr_in     = 32'h0000_0000;
      check_done("sw_mis", 1'b1, 32'h0000_00FF);
      cs_bus_read = 1'b0;
      step();
      check("done_ignored.busy", 32'(busy), 32'd0);

      // LH 0x101 misaligned load
      request(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
      check("lh_mis.mode", 32'(data_bus_mode), 32'd0);
      check_done("lh_mis", 1'b1, 32'h0000_00FF);

      // Illegal funct3 011 on a load
      request(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0);
      check_done("ill011", 1'b1, 32'h0000_00FF);

      // Unsigned size (100) on a store is illegal
      request(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0);
      check("sbu_ill.mode", 32'(data_bus_mode), 32'd0);
      check_done("sbu_ill", 1'b1, 32'h0000_00FF);

      // LW 0x400 with 3 wait cycles: outputs stable, done at +5
      data_bus_ready = 1'b0;
      data_bus_rdata = 32'hCAFE_F00D;
      request(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check_access($sformatf("lw_wait%0d", i), 2'b01, 4'b1111, 32'h0000_0400);
         step();
      end
      data_bus_ready = 1'b1;
      check_access("lw_wait3", 2'b01, 4'b1111, 32'h0000_0400);
      step();
      check_done("lw", 1'b0, 32'hCAFE_F00D);

      // LW 0x400 aborted by reset in a wait cycle: no done pulse
      data_bus_ready = 1'b0;
      request(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
      check_access("lw_abort", 2'b01, 4'b1111, 32'h0000_0400);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.mode", 32'(data_bus_mode), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.dout", data_out, 32'h0);
      data_bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("abort.no_done%0d", i), 32'(done), 32'd0);
      end

      // Read and write together: store wins (SH at 0x202)
      request(1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'h5678_1234);
      check_access("rw_sh", 2'b10, 4'b1100, 32'h0000_0200);
      check("rw_sh.wdata", data_bus_wdata, 32'h1234_0000);
      step();
      check_done("rw_sh", 1'b0, 32'h0);

`ifdef DBUS_TIMEOUT_EN
      // Ready held low: 4 ACCESS cycles, then done+error
      data_bus_ready = 1'b0;
      request(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check_access($sformatf("to_wait%0d", i), 2'b01, 4'b1111, 32'h0000_0500);
         step();
      end
      check_done("timeout", 1'b1, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
